// File: rtl/ws_frame_sequencer.sv
// ---------------------------------------------------------------------------
// ws_frame_sequencer
//
// Frame-level controller for the WS2811 output path. On an accepted start it
// walks the pixel RAM from address 0 to PIXEL_COUNT-1. Each raw 24-bit word is
// offered to the colour-swap stage and serializer over a valid/ready handshake.
// After the last pixel the line is held idle for LATCH_CYCLES clocks. Then a
// one-cycle frame-done pulse is raised.
//
// Optional feature macro: WS_AUTO_REFRESH_EN
//   undefined : one frame per accepted startIN, then back to IDLE.
//   defined   : after DONE the sequencer restarts at pixel 0 by itself. It
//               recaptures the colour order and keeps busyOUT high. Frames
//               repeat until resetIN.
//
// Ports
//   clockIN        in   system clock
//   resetIN        in   synchronous, active-high reset
//   startIN        in   frame start request (sampled in IDLE only)
//   swapCfgIN      in   colour order code, captured at frame start
//   ramAddrOUT     out  pixel RAM read address (registered)
//   ramDataIN      in   pixel RAM read data, one-cycle registered latency
//   pixelDataOUT   out  raw pixel to colour-swap input
//   swapOUT        out  colour order code, frozen for the frame
//   pixelValidOUT  out  pixelDataOUT valid
//   pixelReadyIN   in   serializer accepts pixel
//   busyOUT        out  frame in progress (FETCH..LATCH)
//   frameDoneOUT   out  one-cycle pulse at end of latch period
// ---------------------------------------------------------------------------
module ws_frame_sequencer #(
  parameter int PIXEL_COUNT  = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic                  clockIN,
  input  logic                  resetIN,
  input  logic                  startIN,
  input  logic [2:0]            swapCfgIN,
  output logic [ADDR_WIDTH-1:0] ramAddrOUT,
  input  logic [23:0]           ramDataIN,
  output logic [23:0]           pixelDataOUT,
  output logic [2:0]            swapOUT,
  output logic                  pixelValidOUT,
  input  logic                  pixelReadyIN,
  output logic                  busyOUT,
  output logic                  frameDoneOUT
);

  localparam int LCW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [LCW-1:0]        LAST_LATCH = LCW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_LATCH   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] idx_q,       idx_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic [23:0]           pix_data_q,  pix_data_d;
  logic [2:0]            swap_q,      swap_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic [LCW-1:0]        latch_cnt_q, latch_cnt_d;

  // -------------------------------------------------------------------------
  // Next-state logic. All outputs are registered. Every output change is
  // computed here alongside the state transition that causes it.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ram_addr_d  = ram_addr_q;
    pix_data_d  = pix_data_q;
    swap_d      = swap_q;
    pix_valid_d = pix_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    latch_cnt_d = latch_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (startIN) begin
          swap_d  = swapCfgIN;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end

      // The address is registered on leaving FETCH. The RAM registers its
      // output on leaving WAIT. The word is then stable on ramDataIN during
      // the first PRESENT cycle.
      S_FETCH: begin
        ram_addr_d = idx_q;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        state_d = S_PRESENT;
      end

      // The first PRESENT cycle loads the word and raises valid. While valid
      // is high the data register is left untouched, so backpressure holds
      // it stable. No prefetch: the next pixel is fetched only after this
      // one is accepted.
      S_PRESENT: begin
        if (!pix_valid_q) begin
          pix_data_d  = ramDataIN;
          pix_valid_d = 1'b1;
        end else if (pixelReadyIN) begin
          pix_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            latch_cnt_d = '0;
            state_d     = S_LATCH;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end
        end
      end

      // Line held idle for LATCH_CYCLES clocks. The done pulse is raised on
      // the transition into DONE, so it lines up with the DONE cycle.
      S_LATCH: begin
        if (latch_cnt_q == LAST_LATCH) begin
          latch_cnt_d = '0;
          done_d      = 1'b1;
`ifdef WS_AUTO_REFRESH_EN
          busy_d      = 1'b1;
`else
          busy_d      = 1'b0;
`endif
          state_d     = S_DONE;
        end else begin
          latch_cnt_d = latch_cnt_q + LCW'(1);
        end
      end

      S_DONE: begin
`ifdef WS_AUTO_REFRESH_EN
        // Free-running refresh: restart the frame with a fresh colour order.
        swap_d  = swapCfgIN;
        idx_d   = '0;
        state_d = S_FETCH;
`else
        state_d = S_IDLE;
`endif
      end

      default: begin
        state_d     = S_IDLE;
        pix_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers. A reset in any state returns to IDLE with
  // every output low, so an aborted frame never produces a done pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clockIN) begin
    if (resetIN) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ram_addr_q  <= '0;
      pix_data_q  <= '0;
      swap_q      <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      latch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ram_addr_q  <= ram_addr_d;
      pix_data_q  <= pix_data_d;
      swap_q      <= swap_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      latch_cnt_q <= latch_cnt_d;
    end
  end

  assign ramAddrOUT    = ram_addr_q;
  assign pixelDataOUT  = pix_data_q;
  assign swapOUT       = swap_q;
  assign pixelValidOUT = pix_valid_q;
  assign busyOUT       = busy_q;
  assign frameDoneOUT  = done_q;

endmodule

// File: tb/tb_ws_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ws_frame_sequencer
//
// Bench for ws_frame_sequencer with PIXEL_COUNT=4, ADDR_WIDTH=3, LATCH_CYCLES=8.
// A registered-read RAM holds 24'h010203*(i+1). A timing-rule model (edges
// since fetch start, latch countdown, transfer scoreboard) is compared with the
// DUT at every falling edge. Directed tests add hand-computed expectations.
// Define WS_AUTO_REFRESH_EN to run the free-running refresh scenario instead.
// ---------------------------------------------------------------------------
module tb_ws_frame_sequencer;

  localparam int P  = 4;
  localparam int AW = 3;
  localparam int L  = 8;
`ifdef WS_AUTO_REFRESH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetIN = 1'b1;
  logic          startIN = 1'b0;
  logic [2:0]    swapCfgIN = 3'b000;
  logic [AW-1:0] ramAddrOUT;
  logic [23:0]   ramDataIN = '0;
  logic [23:0]   pixelDataOUT;
  logic [2:0]    swapOUT;
  logic          pixelValidOUT;
  logic          pixelReadyIN = 1'b0;
  logic          busyOUT;
  logic          frameDoneOUT;

  always #5 clk = ~clk;

  ws_frame_sequencer #(.PIXEL_COUNT(P), .ADDR_WIDTH(AW), .LATCH_CYCLES(L)) dut (
    .clockIN(clk), .resetIN(resetIN), .startIN(startIN), .swapCfgIN(swapCfgIN),
    .ramAddrOUT(ramAddrOUT), .ramDataIN(ramDataIN), .pixelDataOUT(pixelDataOUT),
    .swapOUT(swapOUT), .pixelValidOUT(pixelValidOUT), .pixelReadyIN(pixelReadyIN),
    .busyOUT(busyOUT), .frameDoneOUT(frameDoneOUT)
  );

  // Pixel RAM with one-cycle registered read.
  logic [23:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = 24'(24'h010203 * (i + 1));
  always @(posedge clk) ramDataIN <= mem[ramAddrOUT];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Logs of what actually crossed the handshake, and of done pulses.
  int          xfer_cyc[$];
  logic [23:0] xfer_dat[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  // ---------------- behavioural model ----------------
  // The model describes the frame in terms of elapsed edges. After a frame or
  // pixel fetch starts (age 0), the address appears one edge later. The word
  // is valid three edges later. A transfer either starts the next fetch or
  // arms an L-edge latch countdown that ends in a single done cycle.
  logic          m_busy, m_done, m_valid;
  logic [2:0]    m_swap;
  logic [23:0]   m_data;
  logic [AW-1:0] m_addr;
  int            m_idx, m_age, m_latch;

  function automatic void m_reset();
    m_busy = 0; m_done = 0; m_valid = 0; m_swap = '0; m_data = '0; m_addr = '0;
    m_idx = 0; m_age = -1; m_latch = 0;
  endfunction

  function automatic void m_step();
    if (m_done) begin
      m_done = 0;
      if (AUTO) begin m_swap = swapCfgIN; m_idx = 0; m_age = 0; end
    end else if (!m_busy) begin
      if (startIN) begin m_busy = 1; m_swap = swapCfgIN; m_idx = 0; m_age = 0; end
    end else if (m_latch > 0) begin
      m_latch--;
      if (m_latch == 0) begin m_done = 1; m_busy = AUTO; end
    end else if (m_valid) begin
      if (pixelReadyIN) begin
        m_valid = 0;
        if (m_idx == P - 1) m_latch = L;
        else begin m_idx++; m_age = 0; end
      end
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age == 1) m_addr = AW'(m_idx);
      if (m_age == 3) begin m_valid = 1; m_data = mem[m_idx]; m_age = -1; end
    end
  endfunction

  // Compare process: outputs settle after the rising edge and are checked on
  // the falling edge. The model then advances using the inputs the DUT will
  // sample on the next rising edge.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      chk("valid", {31'd0, pixelValidOUT}, {31'd0, m_valid});
      chk("busy",  {31'd0, busyOUT},       {31'd0, m_busy});
      chk("done",  {31'd0, frameDoneOUT},  {31'd0, m_done});
      chk("swap",  {29'd0, swapOUT},       {29'd0, m_swap});
      chk("addr",  32'(ramAddrOUT),        32'(m_addr));
      if (m_valid) chk("data", {8'd0, pixelDataOUT}, {8'd0, m_data});
      if (pixelValidOUT && pixelReadyIN && !resetIN) begin
        xfer_cyc.push_back(cyc);
        xfer_dat.push_back(pixelDataOUT);
      end
      if (frameDoneOUT) begin done_cnt++; done_cyc = cyc; end
      if (resetIN) m_reset(); else m_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    xfer_cyc.delete(); xfer_dat.delete(); done_cnt = 0;
  endtask

  task automatic do_reset();
    resetIN = 1'b1; startIN = 1'b0;
    tick(2);
    resetIN = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_start(output int s);
    startIN = 1'b1; s = cyc;
    tick(1);
    startIN = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n = 0;
    while (!pixelValidOUT && n < budget) begin tick(1); n++; end
    chk({nm, " valid timeout"}, {31'd0, pixelValidOUT}, 32'd1);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!frameDoneOUT && n < budget) begin tick(1); n++; end
    chk({nm, " done timeout"}, {31'd0, frameDoneOUT}, 32'd1);
  endtask

  task automatic wait_xfers(input string nm, input int cnt, input int budget);
    int n = 0;
    while (xfer_dat.size() < cnt && n < budget) begin tick(1); n++; end
    chk({nm, " xfer timeout"}, 32'(xfer_dat.size()), 32'(cnt));
  endtask

  logic [23:0] lit [4];
  initial lit = '{24'h010203, 24'h020406, 24'h030609, 24'h04080C};

  task automatic chk_frame(input string nm, input int base);
    for (int i = 0; i < P; i++)
      chk($sformatf("%s pix%0d", nm, i), {8'd0, xfer_dat[base + i]}, {8'd0, lit[i]});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int s;
    tick(3);
    // Reset state, pinned by hand.
    chk("rst valid", {31'd0, pixelValidOUT}, 32'd0);
    chk("rst busy",  {31'd0, busyOUT}, 32'd0);
    chk("rst done",  {31'd0, frameDoneOUT}, 32'd0);
    chk("rst data",  {8'd0, pixelDataOUT}, 32'd0);
    chk("rst swap",  {29'd0, swapOUT}, 32'd0);
    chk("rst addr",  32'(ramAddrOUT), 32'd0);
    resetIN = 1'b0;
    clear_logs();

`ifndef WS_AUTO_REFRESH_EN
    // 1: ready tied high, four transfers in address order.
    do_reset();
    pixelReadyIN = 1'b1; swapCfgIN = 3'b001;
    pulse_start(s);
    wait_done("t1", 100);
    tick(2);
    chk("t1 count", 32'(xfer_dat.size()), 32'd4);
    if (xfer_dat.size() == 4) begin
      chk_frame("t1", 0);
      // Start sampled at the end of cycle s; valid three edges later, i.e. cycle s+4.
      chk("t1 first", 32'(xfer_cyc[0] - s), 32'd4);
      // Valid rises three edges after each transfer edge: four sampled cycles apart.
      for (int i = 1; i < 4; i++)
        chk($sformatf("t1 gap%0d", i), 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd4);
      chk("t1 done lat", 32'(done_cyc - xfer_cyc[3]), 32'(L + 1));
    end
    chk("t1 done cnt", 32'(done_cnt), 32'd1);

    // 2: backpressure on pixel 1 for 10 cycles.
    do_reset();
    pixelReadyIN = 1'b0;
    pulse_start(s);
    wait_valid("t2 p0", 20);
    pixelReadyIN = 1'b1;
    tick(1);
    pixelReadyIN = 1'b0;
    wait_valid("t2 p1", 20);
    tick(10);
    chk("t2 hold valid", {31'd0, pixelValidOUT}, 32'd1);
    chk("t2 hold data", {8'd0, pixelDataOUT}, 32'h020406);
    chk("t2 hold addr", 32'(ramAddrOUT), 32'd1);
    chk("t2 hold xfers", 32'(xfer_dat.size()), 32'd1);
    pixelReadyIN = 1'b1;
    wait_done("t2", 100);
    tick(1);
    chk("t2 count", 32'(xfer_dat.size()), 32'd4);
    if (xfer_dat.size() == 4) chk_frame("t2", 0);
    chk("t2 done cnt", 32'(done_cnt), 32'd1);

    // 3: colour order frozen for the frame, recaptured at the next start.
    do_reset();
    pixelReadyIN = 1'b1; swapCfgIN = 3'b010;
    pulse_start(s);
    tick(5);
    swapCfgIN = 3'b101;
    tick(3);
    chk("t3 mid swap", {29'd0, swapOUT}, 32'h2);
    wait_done("t3 f1", 100);
    chk("t3 done swap", {29'd0, swapOUT}, 32'h2);
    tick(2);
    chk("t3 idle swap", {29'd0, swapOUT}, 32'h2);
    pulse_start(s);
    chk("t3 new swap", {29'd0, swapOUT}, 32'h5);
    wait_done("t3 f2", 100);
    tick(1);

    // 4: start pulses during PRESENT and LATCH are ignored.
    do_reset();
    pixelReadyIN = 1'b0; swapCfgIN = 3'b111;
    pulse_start(s);
    wait_valid("t4", 20);
    pulse_start(s);
    pixelReadyIN = 1'b1;
    wait_xfers("t4", 4, 100);
    tick(3);
    pulse_start(s);
    wait_done("t4", 100);
    tick(20);
    chk("t4 done cnt", 32'(done_cnt), 32'd1);
    chk("t4 idle busy", {31'd0, busyOUT}, 32'd0);
    chk("t4 count", 32'(xfer_dat.size()), 32'd4);
    chk("t4 swap", {29'd0, swapOUT}, 32'h7);

    // 5: reset during pixel 2 PRESENT, then a clean restart at address 0.
    do_reset();
    pixelReadyIN = 1'b1; swapCfgIN = 3'b011;
    pulse_start(s);
    wait_xfers("t5", 2, 100);
    pixelReadyIN = 1'b0;
    wait_valid("t5 p2", 20);
    chk("t5 pre addr", 32'(ramAddrOUT), 32'd2);
    resetIN = 1'b1;
    tick(1);
    chk("t5 valid", {31'd0, pixelValidOUT}, 32'd0);
    chk("t5 data",  {8'd0, pixelDataOUT}, 32'd0);
    chk("t5 addr",  32'(ramAddrOUT), 32'd0);
    chk("t5 swap",  {29'd0, swapOUT}, 32'd0);
    chk("t5 busy",  {31'd0, busyOUT}, 32'd0);
    chk("t5 done",  {31'd0, frameDoneOUT}, 32'd0);
    resetIN = 1'b0;
    tick(3);
    chk("t5 no done", 32'(done_cnt), 32'd0);
    clear_logs();
    pixelReadyIN = 1'b1;
    pulse_start(s);
    wait_done("t5", 100);
    tick(1);
    chk("t5 count", 32'(xfer_dat.size()), 32'd4);
    if (xfer_dat.size() == 4) chk_frame("t5", 0);
`else
    // 6: one start, three back-to-back frames, busy never drops.
    begin
      int low_seen = 0;
      int n = 0;
      do_reset();
      pixelReadyIN = 1'b1; swapCfgIN = 3'b100;
      pulse_start(s);
      while (done_cnt < 3 && n < 300) begin
        if (!busyOUT) low_seen++;
        if (done_cnt == 1) swapCfgIN = 3'b001;
        tick(1); n++;
      end
      chk("t6 done cnt", 32'(done_cnt), 32'd3);
      chk("t6 busy low", 32'(low_seen), 32'd0);
      chk("t6 count", 32'(xfer_dat.size()), 32'd12);
      if (xfer_dat.size() == 12)
        for (int f = 0; f < 3; f++) chk_frame($sformatf("t6 f%0d", f), f * 4);
      chk("t6 swap", {29'd0, swapOUT}, 32'h1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
